// File: rtl/amm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : amm_rr_arbiter
// Purpose  : Round-robin sharing of one Avalon-MM slave among NUM_M masters,
//            with an in-order response FIFO routing pipelined read data back.
// Revision : 1.0 - initial release
// ============================================================================
module amm_rr_arbiter #(
    parameter int NUM_M    = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int BURST_W  = 2,
    parameter int MAX_PEND = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_address_i,
    input  logic [NUM_M-1:0]          m_read_i,
    input  logic [NUM_M-1:0]          m_write_i,
    input  logic [NUM_M*DATA_W-1:0]   m_writedata_i,
    input  logic [NUM_M*DATA_W/8-1:0] m_byteenable_i,
    input  logic [NUM_M*BURST_W-1:0]  m_burstcount_i,
    output logic [NUM_M-1:0]          m_waitrequest_o,
    output logic [DATA_W-1:0]         m_readdata_o,
    output logic [NUM_M-1:0]          m_readdatavalid_o,
    output logic [ADDR_W-1:0]         s_address_o,
    output logic                      s_read_o,
    output logic                      s_write_o,
    output logic [DATA_W-1:0]         s_writedata_o,
    output logic [DATA_W/8-1:0]       s_byteenable_o,
    output logic [BURST_W-1:0]        s_burstcount_o,
    input  logic                      s_waitrequest_i,
    input  logic [DATA_W-1:0]         s_readdata_i,
    input  logic                      s_readdatavalid_i
);

    localparam int c_be_w  = DATA_W / 8;
    localparam int c_id_w  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int c_ptr_w = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int c_cnt_w = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    logic [ADDR_W-1:0]  w_addr  [NUM_M];
    logic [DATA_W-1:0]  w_wdata [NUM_M];
    logic [c_be_w-1:0]  w_be    [NUM_M];
    logic [BURST_W-1:0] w_bc    [NUM_M];

    for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
        assign w_addr[k]  = m_address_i[k*ADDR_W +: ADDR_W];
        assign w_wdata[k] = m_writedata_i[k*DATA_W +: DATA_W];
        assign w_be[k]    = m_byteenable_i[k*c_be_w +: c_be_w];
        assign w_bc[k]    = m_burstcount_i[k*BURST_W +: BURST_W];
    end

    state_t             state_q, state_d;
    logic [c_id_w-1:0]  grant_q, grant_d;
    logic [c_id_w-1:0]  last_q, last_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [ADDR_W-1:0]  baddr_q, baddr_d;
    logic [BURST_W-1:0] bbc_q, bbc_d;

    logic [c_id_w-1:0]  fid_q [MAX_PEND];
    logic [BURST_W-1:0] fbc_q [MAX_PEND];
    logic [c_ptr_w-1:0] wptr_q, rptr_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [BURST_W-1:0] hrem_q;

    logic [NUM_M-1:0]   w_req;
    logic [c_id_w-1:0]  w_arb_id;
    logic               w_arb_hit;
    logic               w_full;
    logic               w_stall;
    logic               w_push;
    logic               w_pop;
    logic               w_rvalid;
    logic [BURST_W-1:0] w_head_bc;

    assign w_req  = m_read_i | m_write_i;
    assign w_full = (cnt_q == c_cnt_w'(MAX_PEND));

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        logic [c_id_w-1:0] cand;
        w_arb_id  = last_q;
        w_arb_hit = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = c_id_w'((int'(last_q) + i) % NUM_M);
            if (!w_arb_hit && w_req[cand]) begin
                w_arb_id  = cand;
                w_arb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        beats_d         = beats_q;
        baddr_d         = baddr_q;
        bbc_d           = bbc_q;
        m_waitrequest_o = '1;
        s_address_o     = '0;
        s_read_o        = 1'b0;
        s_write_o       = 1'b0;
        s_writedata_o   = '0;
        s_byteenable_o  = '0;
        s_burstcount_o  = '0;
        w_stall         = 1'b0;
        w_push          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    grant_d = w_arb_id;
                    last_d  = w_arb_id;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                s_address_o    = w_addr[grant_q];
                s_writedata_o  = w_wdata[grant_q];
                s_byteenable_o = w_be[grant_q];
                s_burstcount_o = w_bc[grant_q];
                // Full check uses pre-pop occupancy: a read may wait one extra cycle.
                w_stall        = m_read_i[grant_q] && w_full;
                s_read_o       = m_read_i[grant_q] && !w_stall;
                s_write_o      = m_write_i[grant_q] && !m_read_i[grant_q];
                m_waitrequest_o[grant_q] = s_waitrequest_i | w_stall;
                if (s_read_o && !s_waitrequest_i) begin
                    w_push  = 1'b1;
                    state_d = ST_IDLE;
                end else if (s_write_o && !s_waitrequest_i) begin
                    if (w_bc[grant_q] == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_d = w_bc[grant_q] - BURST_W'(1);
                        baddr_d = w_addr[grant_q];
                        bbc_d   = w_bc[grant_q];
                        state_d = ST_WBURST;
                    end
                end
            end
            ST_WBURST: begin
                s_address_o    = baddr_q;
                s_burstcount_o = bbc_q;
                s_writedata_o  = w_wdata[grant_q];
                s_byteenable_o = w_be[grant_q];
                s_write_o      = m_write_i[grant_q];
                m_waitrequest_o[grant_q] = s_waitrequest_i;
                if (s_write_o && !s_waitrequest_i) begin
                    if (beats_q == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_d = beats_q - BURST_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // hrem_q==0 means the head entry has not yet returned any beat.
    always_comb begin
        w_head_bc         = (hrem_q == '0) ? fbc_q[rptr_q] : hrem_q;
        w_rvalid          = s_readdatavalid_i && (cnt_q != '0) && !rst_i;
        w_pop             = w_rvalid && (w_head_bc == BURST_W'(1));
        m_readdatavalid_o = '0;
        if (w_rvalid) begin
            m_readdatavalid_o[fid_q[rptr_q]] = 1'b1;
        end
    end

    assign m_readdata_o = s_readdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= c_id_w'(NUM_M - 1);
            beats_q <= '0;
            baddr_q <= '0;
            bbc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            hrem_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            baddr_q <= baddr_d;
            bbc_q   <= bbc_d;
            if (w_push) begin
                wptr_q <= wptr_q + c_ptr_w'(1);
            end
            if (w_rvalid) begin
                hrem_q <= w_pop ? '0 : (w_head_bc - BURST_W'(1));
            end
            if (w_pop) begin
                rptr_q <= rptr_q + c_ptr_w'(1);
            end
            cnt_q <= cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fid_q[wptr_q] <= grant_q;
            fbc_q[wptr_q] <= w_bc[grant_q];
        end
    end

    a_rdv_without_pending : assert property (@(posedge clk_i) disable iff (rst_i)
        !(s_readdatavalid_i && (cnt_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_amm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_amm_rr_arbiter
// Purpose  : Directed self-checking bench for amm_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amm_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m_address;
    logic [3:0]   m_read;
    logic [3:0]   m_write;
    logic [255:0] m_writedata;
    logic [31:0]  m_byteenable;
    logic [7:0]   m_burstcount;
    logic [3:0]   m_waitrequest;
    logic [63:0]  m_readdata;
    logic [3:0]   m_readdatavalid;
    logic [7:0]   s_address;
    logic         s_read;
    logic         s_write;
    logic [63:0]  s_writedata;
    logic [7:0]   s_byteenable;
    logic [1:0]   s_burstcount;
    logic         s_waitrequest;
    logic [63:0]  s_readdata;
    logic         s_readdatavalid;

    int checks = 0;
    int errors = 0;

    amm_rr_arbiter #(
        .NUM_M(4), .ADDR_W(8), .DATA_W(64), .BURST_W(2), .MAX_PEND(4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .m_address_i       (m_address),
        .m_read_i          (m_read),
        .m_write_i         (m_write),
        .m_writedata_i     (m_writedata),
        .m_byteenable_i    (m_byteenable),
        .m_burstcount_i    (m_burstcount),
        .m_waitrequest_o   (m_waitrequest),
        .m_readdata_o      (m_readdata),
        .m_readdatavalid_o (m_readdatavalid),
        .s_address_o       (s_address),
        .s_read_o          (s_read),
        .s_write_o         (s_write),
        .s_writedata_o     (s_writedata),
        .s_byteenable_o    (s_byteenable),
        .s_burstcount_o    (s_burstcount),
        .s_waitrequest_i   (s_waitrequest),
        .s_readdata_i      (s_readdata),
        .s_readdatavalid_i (s_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] wexp;
        int         exp_g;

        rst             = 1'b1;
        m_address       = '0;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        m_byteenable    = '1;
        m_burstcount    = {4{2'd1}};
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
        step();
        step();

        // Reset state
        @(negedge clk);
        chk("rst_wait",   m_waitrequest, 4'hF);
        chk("rst_rdv",    m_readdatavalid, 4'h0);
        chk("rst_sread",  s_read, 1'b0);
        chk("rst_swrite", s_write, 1'b0);
        chk("rst_saddr",  s_address, 8'h00);
        chk("rst_swdata", s_writedata, 64'h0);
        step();

        // Single master write then read
        rst               = 1'b0;
        m_write           = 4'b0001;
        m_address[7:0]    = 8'h10;
        m_writedata[63:0] = 64'hDEADBEEF_00000001;
        @(negedge clk);
        chk("t1_idle_wait",   m_waitrequest, 4'hF);
        chk("t1_idle_swrite", s_write, 1'b0);
        step();
        @(negedge clk);
        chk("t1_swrite", s_write, 1'b1);
        chk("t1_saddr",  s_address, 8'h10);
        chk("t1_swdata", s_writedata, 64'hDEADBEEF_00000001);
        chk("t1_wait",   m_waitrequest, 4'b1110);
        chk("t1_sbc",    s_burstcount, 2'd1);
        step();
        m_write = 4'b0000;
        m_read  = 4'b0001;
        @(negedge clk);
        chk("t1_idle2_sread", s_read, 1'b0);
        step();
        @(negedge clk);
        chk("t1_sread",      s_read, 1'b1);
        chk("t1_rd_saddr",   s_address, 8'h10);
        chk("t1_rd_wait",    m_waitrequest, 4'b1110);
        step();
        m_read          = 4'b0000;
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hDEADBEEF_00000001;
        @(negedge clk);
        chk("t1_rdv",   m_readdatavalid, 4'b0001);
        chk("t1_rdata", m_readdata, 64'hDEADBEEF_00000001);
        step();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t1_rdv_off", m_readdatavalid, 4'b0000);
        step();

        // Fairness: last grant was 0, so the rotation starts at 1
        for (int k = 0; k < 4; k++) m_address[k*8 +: 8] = 8'h20 + 8'(k);
        m_write = 4'hF;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i + 1) % 4;
            @(negedge clk);
            chk("fair_idle_wait", m_waitrequest, 4'hF);
            step();
            wexp = 4'b0001 << exp_g;
            wexp = ~wexp;
            @(negedge clk);
            chk("fair_addr", s_address, 64'(8'h20 + 8'(exp_g)));
            chk("fair_wait", m_waitrequest, wexp);
            step();
        end
        m_write = 4'b0000;
        @(negedge clk);
        step();

        // Write burst from m2 holds off m1
        m_write              = 4'b0100;
        m_address[23:16]     = 8'h30;
        m_writedata[191:128] = 64'hB0B0_0000_0000_0001;
        m_burstcount[5:4]    = 2'd2;
        @(negedge clk);
        step();
        m_write             = 4'b0110;
        m_address[15:8]     = 8'h40;
        m_writedata[127:64] = 64'h1111;
        @(negedge clk);
        chk("burst_b1_swrite", s_write, 1'b1);
        chk("burst_b1_addr",   s_address, 8'h30);
        chk("burst_b1_bc",     s_burstcount, 2'd2);
        chk("burst_b1_wait",   m_waitrequest, 4'b1011);
        chk("burst_b1_wdata",  s_writedata, 64'hB0B0_0000_0000_0001);
        step();
        m_address[23:16]     = 8'h31;
        m_writedata[191:128] = 64'hB0B0_0000_0000_0002;
        s_waitrequest        = 1'b1;
        @(negedge clk);
        chk("burst_stall_wait", m_waitrequest, 4'hF);
        chk("burst_stall_addr", s_address, 8'h30);
        step();
        s_waitrequest = 1'b0;
        @(negedge clk);
        chk("burst_b2_wait",  m_waitrequest, 4'b1011);
        chk("burst_b2_wdata", s_writedata, 64'hB0B0_0000_0000_0002);
        chk("burst_b2_bc",    s_burstcount, 2'd2);
        chk("burst_b2_addr",  s_address, 8'h30);
        step();
        m_write           = 4'b0010;
        m_burstcount[5:4] = 2'd1;
        @(negedge clk);
        chk("burst_idle_wait",   m_waitrequest, 4'hF);
        chk("burst_idle_swrite", s_write, 1'b0);
        step();
        @(negedge clk);
        chk("burst_m1_addr", s_address, 8'h40);
        chk("burst_m1_wait", m_waitrequest, 4'b1101);
        step();
        m_write = 4'b0000;

        // Pipelined reads, slave latency 3 cycles
        m_address[7:0]   = 8'h50;
        m_address[15:8]  = 8'h51;
        m_address[31:24] = 8'h53;
        m_read = 4'b0001;
        @(negedge clk);
        step();
        m_read = 4'b1011;
        @(negedge clk);
        chk("pr_m0_sread", s_read, 1'b1);
        chk("pr_m0_addr",  s_address, 8'h50);
        chk("pr_m0_wait",  m_waitrequest, 4'b1110);
        step();
        m_read = 4'b1010;
        @(negedge clk);
        chk("pr_idle_wait", m_waitrequest, 4'hF);
        step();
        @(negedge clk);
        chk("pr_m1_addr", s_address, 8'h51);
        chk("pr_m1_wait", m_waitrequest, 4'b1101);
        step();
        m_read          = 4'b1000;
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hA0;
        @(negedge clk);
        chk("pr_rdv0",   m_readdatavalid, 4'b0001);
        chk("pr_rdata0", m_readdata, 64'hA0);
        step();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("pr_m3_addr", s_address, 8'h53);
        chk("pr_m3_wait", m_waitrequest, 4'b0111);
        chk("pr_rdv_gap", m_readdatavalid, 4'b0000);
        step();
        m_read          = 4'b0000;
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hA1;
        @(negedge clk);
        chk("pr_rdv1", m_readdatavalid, 4'b0010);
        step();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("pr_rdv_gap2", m_readdatavalid, 4'b0000);
        step();
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hA3;
        @(negedge clk);
        chk("pr_rdv3",   m_readdatavalid, 4'b1000);
        chk("pr_rdata3", m_readdata, 64'hA3);
        step();
        s_readdatavalid = 1'b0;

        // FIFO full: four reads from m0 outstanding, then m2 must wait
        m_address[7:0]   = 8'h60;
        m_address[23:16] = 8'h62;
        m_read = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step();
            @(negedge clk);
            chk("full_fill_sread", s_read, 1'b1);
            step();
        end
        m_read = 4'b0100;
        @(negedge clk);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_stall_wait",  m_waitrequest, 4'hF);
            chk("full_stall_sread", s_read, 1'b0);
            step();
        end
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hF0;
        @(negedge clk);
        chk("full_pop_wait",  m_waitrequest, 4'hF);
        chk("full_pop_sread", s_read, 1'b0);
        chk("full_pop_rdv",   m_readdatavalid, 4'b0001);
        step();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("full_issue_sread", s_read, 1'b1);
        chk("full_issue_wait",  m_waitrequest, 4'b1011);
        chk("full_issue_addr",  s_address, 8'h62);
        step();
        m_read = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1'b1;
            @(negedge clk);
            chk("full_drain_rdv", m_readdatavalid, (i < 3) ? 4'b0001 : 4'b0100);
            step();
        end
        s_readdatavalid = 1'b0;
        step();

        // Reset in the last beat of a burst with a read still outstanding
        m_read = 4'b0001;
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        m_read            = 4'b0000;
        m_write           = 4'b0010;
        m_burstcount[3:2] = 2'd2;
        m_address[15:8]   = 8'h70;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("rb_cmd_swrite", s_write, 1'b1);
        step();
        rst             = 1'b1;
        s_readdatavalid = 1'b1;
        @(negedge clk);
        chk("rb_wburst_wait", m_waitrequest, 4'b1101);
        chk("rb_rst_rdv",     m_readdatavalid, 4'b0000);
        step();
        rst             = 1'b0;
        s_readdatavalid = 1'b0;
        m_write         = 4'b1011;
        m_burstcount    = {4{2'd1}};
        m_address[7:0]  = 8'h80;
        @(negedge clk);
        chk("rb_post_swrite", s_write, 1'b0);
        chk("rb_post_wait",   m_waitrequest, 4'hF);
        chk("rb_post_rdv",    m_readdatavalid, 4'b0000);
        step();
        @(negedge clk);
        chk("rb_first_addr", s_address, 8'h80);
        chk("rb_first_wait", m_waitrequest, 4'b1110);
        step();
        m_write = 4'b0000;
        m_read  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step();
            @(negedge clk);
            chk("rb_empty_sread", s_read, 1'b1);
            step();
        end
        m_read = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1'b1;
            @(negedge clk);
            chk("rb_drain_rdv", m_readdatavalid, 4'b0001);
            step();
        end
        s_readdatavalid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
